// File: rtl/puf_scan_window_sequencer.sv
// puf_scan_window_sequencer
//
// Generates the scan-enable (SE) waveform for the PUF authentication path.
// SE stays high for an authentication phase of n_auth cycles. Then n_rep scan
// windows follow. Each window holds SE low for l_scan cycles. A gap of l_gap
// cycles with SE high separates consecutive windows. No gap follows the last
// window. The block sits between the authentication controller and the
// scan-chain mux.
//
// Optional feature: define PUF_SCAN_CAPTURE_EN to add the capture_stb output.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           single-cycle request, accepted only from IDLE
//   abort           synchronous abort of a running sequence
//   n_auth          authentication phase length (cycles, SE high)
//   l_scan          scan window length (cycles, SE low)
//   l_gap           gap length between windows (cycles, SE high)
//   n_rep           number of scan windows (0 behaves as 1)
//   se_signal       registered scan enable, low only inside scan windows
//   busy            sequence in progress
//   done            one-cycle pulse on normal completion
//   aborted         sticky abort flag, cleared by the next accepted start
//   win_idx         index of the current or last scan window
//   current_count   cycles elapsed since start, saturating at all-ones
//   capture_stb     (PUF_SCAN_CAPTURE_EN only) pulse on the last SE-low cycle
//                   of each non-empty window
module puf_scan_window_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_auth,
  input  logic [CNT_W-1:0] l_scan,
  input  logic [CNT_W-1:0] l_gap,
  input  logic [REP_W-1:0] n_rep,
  output logic             se_signal,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [REP_W-1:0] win_idx,
`ifdef PUF_SCAN_CAPTURE_EN
  output logic             capture_stb,
`endif
  output logic [CNT_W-1:0] current_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AUTH = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int NW = 3 + REP_W;

  logic [2:0]       state, next_state;
  logic [CNT_W-1:0] phase_cnt, next_phase;
  logic [REP_W-1:0] next_win;
  logic [CNT_W-1:0] sh_auth, sh_scan, sh_gap;
  logic [REP_W-1:0] sh_last;
  logic             accept, running;
  logic [CNT_W-1:0] cfg_scan, cfg_gap;
  logic [REP_W-1:0] cfg_last;

  // Resolve where the sequence lands when window w is entered. Zero-length
  // phases are skipped here, so no idle cycle is inserted for them. l_scan
  // is the same for every window. If it is 0 and l_gap is also 0, every
  // remaining window is empty and the sequence ends at the last index.
  function automatic logic [NW-1:0] enter_window(input logic [REP_W-1:0] w,
                                                 input logic [CNT_W-1:0] scan_len,
                                                 input logic [CNT_W-1:0] gap_len,
                                                 input logic [REP_W-1:0] last);
    if (scan_len != '0)     return {S_SCAN, w};
    else if (w == last)     return {S_DONE, w};
    else if (gap_len != '0) return {S_GAP, w};
    else                    return {S_DONE, last};
  endfunction

  assign accept  = (state == S_IDLE) && start;
  assign running = (state == S_AUTH) || (state == S_SCAN) || (state == S_GAP);

  // At the accepting edge the shadow registers are not loaded yet.
  // Decisions taken on that edge therefore use the live inputs.
  assign cfg_scan = accept ? l_scan : sh_scan;
  assign cfg_gap  = accept ? l_gap  : sh_gap;
  assign cfg_last = accept ? ((n_rep == '0) ? '0 : n_rep - 1'b1) : sh_last;

  always_comb begin
    next_state = state;
    next_win   = win_idx;
    next_phase = phase_cnt + 1'b1;
    case (state)
      S_IDLE: begin
        next_phase = '0;
        if (start) begin
          if (n_auth != '0) {next_state, next_win} = {S_AUTH, {REP_W{1'b0}}};
          else {next_state, next_win} = enter_window('0, cfg_scan, cfg_gap, cfg_last);
        end
      end
      S_AUTH: begin
        if (phase_cnt == sh_auth - 1'b1) begin
          next_phase = '0;
          {next_state, next_win} = enter_window('0, cfg_scan, cfg_gap, cfg_last);
        end
      end
      S_SCAN: begin
        if (phase_cnt == sh_scan - 1'b1) begin
          next_phase = '0;
          if (win_idx == sh_last)  next_state = S_DONE;
          else if (sh_gap != '0)   next_state = S_GAP;
          else                     next_win   = win_idx + 1'b1;
        end
      end
      S_GAP: begin
        if (phase_cnt == sh_gap - 1'b1) begin
          next_phase = '0;
          {next_state, next_win} = enter_window(win_idx + 1'b1, cfg_scan, cfg_gap, cfg_last);
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
        next_phase = '0;
      end
      default: begin
        next_state = S_IDLE;
        next_phase = '0;
      end
    endcase
    if (running && abort) begin
      next_state = S_IDLE;
      next_phase = '0;
      next_win   = win_idx;
    end
  end

  // All outputs are registered from the next-state decode. SE therefore
  // reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      phase_cnt     <= '0;
      win_idx       <= '0;
      se_signal     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      current_count <= '0;
      sh_auth       <= '0;
      sh_scan       <= '0;
      sh_gap        <= '0;
      sh_last       <= '0;
    end else begin
      state     <= next_state;
      phase_cnt <= next_phase;
      win_idx   <= next_win;
      se_signal <= (next_state != S_SCAN);
      busy      <= (next_state == S_AUTH) || (next_state == S_SCAN) || (next_state == S_GAP);
      done      <= (next_state == S_DONE);
      if (accept) begin
        sh_auth       <= n_auth;
        sh_scan       <= l_scan;
        sh_gap        <= l_gap;
        sh_last       <= cfg_last;
        aborted       <= 1'b0;
        current_count <= '0;
      end else begin
        if (running && (current_count != '1)) current_count <= current_count + 1'b1;
        if (running && abort) aborted <= 1'b1;
      end
    end
  end

`ifdef PUF_SCAN_CAPTURE_EN
  // The strobe is high while the entered cycle is the last SE-low cycle of
  // a window. An abort leads to IDLE, which suppresses any pending strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) capture_stb <= 1'b0;
    else        capture_stb <= (next_state == S_SCAN) && (next_phase == cfg_scan - 1'b1);
  end
`endif

endmodule

// File: tb/tb_puf_scan_window_sequencer.sv
// tb_puf_scan_window_sequencer
//
// Self-checking bench for puf_scan_window_sequencer. A waveform model turns
// each accepted start into a queue of expected per-cycle outputs. That queue
// is built from the phase lengths. A compare process checks the DUT against
// the queue on every falling edge. Directed tests add hand-computed literals.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_puf_scan_window_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start, abort;
  logic [15:0] n_auth, l_scan, l_gap;
  logic [3:0]  n_rep;
  logic        se_signal, busy, done, aborted, capture_stb;
  logic [3:0]  win_idx;
  logic [15:0] current_count;

  logic        s_start, s_abort;
  logic [3:0]  s_n_auth, s_l_scan, s_l_gap, s_n_rep;
  logic        s_se, s_busy, s_done, s_aborted, s_cap;
  logic [3:0]  s_win, s_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  puf_scan_window_sequencer #(.CNT_W(16), .REP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_auth(n_auth), .l_scan(l_scan), .l_gap(l_gap), .n_rep(n_rep),
    .se_signal(se_signal), .busy(busy), .done(done), .aborted(aborted),
    .win_idx(win_idx),
`ifdef PUF_SCAN_CAPTURE_EN
    .capture_stb(capture_stb),
`endif
    .current_count(current_count)
  );

  puf_scan_window_sequencer #(.CNT_W(4), .REP_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .n_auth(s_n_auth), .l_scan(s_l_scan), .l_gap(s_l_gap), .n_rep(s_n_rep),
    .se_signal(s_se), .busy(s_busy), .done(s_done), .aborted(s_aborted),
    .win_idx(s_win),
`ifdef PUF_SCAN_CAPTURE_EN
    .capture_stb(s_cap),
`endif
    .current_count(s_count)
  );

`ifndef PUF_SCAN_CAPTURE_EN
  assign capture_stb = 1'b0;
  assign s_cap = 1'b0;
`endif

  typedef struct packed {
    logic        se;
    logic        busy;
    logic        done;
    logic [3:0]  win;
    logic [15:0] cnt;
    logic        cap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic e_abt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Expected waveform: the AUTH cycles, then each window followed by its gap
  // except after the last window, then one done cycle. The busy-cycle index
  // gives the elapsed count.
  task automatic buildSequence(input int na, input int ls, input int lg, input int nr);
    int k;
    int last;
    exp_t r;
    last = (nr == 0) ? 0 : nr - 1;
    k = 0;
    exp_q.delete();
    for (int i = 0; i < na; i++) begin
      r.se = 1'b1; r.busy = 1'b1; r.done = 1'b0; r.win = 4'd0; r.cnt = sat16(k); r.cap = 1'b0;
      exp_q.push_back(r); k++;
    end
    for (int w = 0; w <= last; w++) begin
      for (int i = 0; i < ls; i++) begin
        r.se = 1'b0; r.busy = 1'b1; r.done = 1'b0; r.win = 4'(w); r.cnt = sat16(k);
        r.cap = (i == ls - 1);
        exp_q.push_back(r); k++;
      end
      if (w < last) begin
        for (int i = 0; i < lg; i++) begin
          r.se = 1'b1; r.busy = 1'b1; r.done = 1'b0; r.win = 4'(w); r.cnt = sat16(k); r.cap = 1'b0;
          exp_q.push_back(r); k++;
        end
      end
    end
    r.se = 1'b1; r.busy = 1'b0; r.done = 1'b1; r.win = 4'(last); r.cnt = sat16(k); r.cap = 1'b0;
    exp_q.push_back(r);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e.se = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.win = '0; e.cnt = '0; e.cap = 1'b0;
      e_abt = 1'b0;
      exp_q.delete();
    end else if (e.busy && abort) begin
      exp_q.delete();
      e.se = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.cap = 1'b0;
      e.cnt = sat16(int'(e.cnt) + 1);
      e_abt = 1'b1;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else if (!e.done && start) begin
      buildSequence(int'(n_auth), int'(l_scan), int'(l_gap), int'(n_rep));
      e_abt = 1'b0;
      e = exp_q.pop_front();
    end else begin
      e.se = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.cap = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp_se", se_signal, e.se);
      checkOutput("cmp_busy", busy, e.busy);
      checkOutput("cmp_done", done, e.done);
      checkOutput("cmp_aborted", aborted, e_abt);
      checkOutput("cmp_win_idx", win_idx, e.win);
      checkOutput("cmp_count", current_count, e.cnt);
`ifdef PUF_SCAN_CAPTURE_EN
      checkOutput("cmp_capture", capture_stb, e.cap);
`endif
    end
  end

  task automatic applyStimulus(input int na, input int ls, input int lg, input int nr);
    n_auth = 16'(na); l_scan = 16'(ls); l_gap = 16'(lg); n_rep = 4'(nr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxc, output int nbusy, output int nlow,
                          output logic [31:0] pat, output int cnt_d, output int win_d,
                          output int ncap);
    bit seen;
    seen = 0; nbusy = 0; nlow = 0; pat = '0; cnt_d = 0; win_d = 0; ncap = 0;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin
        seen = 1;
        cnt_d = int'(current_count);
        win_d = int'(win_idx);
        break;
      end
      if (busy) begin
        nbusy++;
        pat = {pat[30:0], se_signal};
        if (!se_signal) nlow++;
      end
      if (capture_stb) ncap++;
      @(negedge clk);
    end
    if (!seen) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nb, nl, cd, wd, nc, lowc, ndone, sb, s_c18, s_cd;
    logic [31:0] pat;
    bit seen;
    start = 0; abort = 0; n_auth = '0; l_scan = '0; l_gap = '0; n_rep = '0;
    s_start = 0; s_abort = 0; s_n_auth = '0; s_l_scan = '0; s_l_gap = '0; s_n_rep = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_se", se_signal, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_win", win_idx, 0);
    checkOutput("rst_count", current_count, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single window; start in the DONE cycle is ignored.
    applyStimulus(3, 4, 2, 1);
    waitDone("t1", 50, nb, nl, pat, cd, wd, nc);
    checkOutput("t1_busy_cycles", nb, 7);
    checkOutput("t1_se_pattern", pat, 32'b1110000);
    checkOutput("t1_count_at_done", cd, 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t1_start_in_done_ignored", busy, 0);
    @(negedge clk);

    // Test 2: three windows with gaps.
    applyStimulus(2, 3, 2, 3);
    waitDone("t2", 60, nb, nl, pat, cd, wd, nc);
    checkOutput("t2_se_pattern", pat, 32'b110001100011000);
    checkOutput("t2_win_at_done", wd, 2);
    checkOutput("t2_count_at_done", cd, 15);
    @(negedge clk);

    // Test 3: zero-length phases.
    applyStimulus(0, 2, 3, 0);
    waitDone("t3a", 30, nb, nl, pat, cd, wd, nc);
    checkOutput("t3a_busy_cycles", nb, 2);
    checkOutput("t3a_se_low", nl, 2);
    @(negedge clk);
    applyStimulus(2, 0, 1, 2);
    waitDone("t3b", 30, nb, nl, pat, cd, wd, nc);
    checkOutput("t3b_se_never_low", nl, 0);
    checkOutput("t3b_busy_cycles", nb, 3);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    waitDone("t3c", 10, nb, nl, pat, cd, wd, nc);
    checkOutput("t3c_busy_cycles", nb, 0);
    @(negedge clk);

    // Test 4: abort in the second SCAN cycle.
    applyStimulus(1, 10, 2, 1);
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!se_signal) lowc++;
      if (lowc == 2) break;
      @(negedge clk);
    end
    checkOutput("t4_reached_scan2", lowc, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t4_abort_se", se_signal, 1);
    checkOutput("t4_abort_busy", busy, 0);
    checkOutput("t4_abort_flag", aborted, 1);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checkOutput("t4_no_done", ndone, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t4_idle_abort_no_effect", aborted, 1);
    n_auth = 16'd2; l_scan = 16'd2; l_gap = 16'd0; n_rep = 4'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("t4_start_wins_busy", busy, 1);
    checkOutput("t4_start_clears_aborted", aborted, 0);
    waitDone("t4b", 30, nb, nl, pat, cd, wd, nc);
    @(negedge clk);

    // Test 5: config changes and start pulses while busy are ignored.
    applyStimulus(3, 4, 2, 2);
    repeat (2) @(negedge clk);
    n_auth = 16'd9; l_scan = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("t5", 60, nb, nl, pat, cd, wd, nc);
    checkOutput("t5_count_at_done", cd, 13);
    checkOutput("t5_win_at_done", wd, 1);
    @(negedge clk);

    // Test 5b: saturation on the CNT_W=4 instance (20 busy cycles).
    s_n_auth = 4'd15; s_l_scan = 4'd5; s_l_gap = 4'd0; s_n_rep = 4'd1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    sb = 0; s_c18 = -1; s_cd = -1; seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (s_done) begin
        seen = 1;
        s_cd = int'(s_count);
        break;
      end
      if (s_busy) sb++;
      if (sb == 18 && s_c18 < 0) s_c18 = int'(s_count);
      @(negedge clk);
    end
    checkOutput("t5s_done_seen", seen, 1);
    checkOutput("t5s_busy_cycles", sb, 20);
    checkOutput("t5s_count_mid_saturated", s_c18, 15);
    checkOutput("t5s_count_at_done", s_cd, 15);
    @(negedge clk);

    // Test 6: two windows of 3 cycles; one strobe per window.
    applyStimulus(1, 3, 1, 2);
    waitDone("t6", 30, nb, nl, pat, cd, wd, nc);
    checkOutput("t6_se_low", nl, 6);
`ifdef PUF_SCAN_CAPTURE_EN
    checkOutput("t6_capture_pulses", nc, 2);
`endif
    @(negedge clk);

    // Test 6b: reset asserted in the middle of a scan window.
    applyStimulus(1, 10, 1, 2);
    repeat (3) @(negedge clk);
    checkOutput("t6b_in_scan", se_signal, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6b_rst_se", se_signal, 1);
    checkOutput("t6b_rst_busy", busy, 0);
    checkOutput("t6b_rst_done", done, 0);
    checkOutput("t6b_rst_win", win_idx, 0);
    checkOutput("t6b_rst_count", current_count, 0);
    checkOutput("t6b_rst_capture", capture_stb, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6b_idle_after_reset", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
